// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache line fills and dcache fills/writebacks onto one memory port,
// dcache first but with a bounded number of consecutive dcache wins while the icache waits.
module mem_arbiter #(
   parameter int LINE_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [31:0]       ic_addr,
   output logic              ic_ack,
   output logic [LINE_W-1:0] ic_data,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [31:0]       dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ack,
   output logic [LINE_W-1:0] dc_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t        state;
   logic [CW-1:0] starve_cnt;
   logic          dc_win;
   assign dc_win = dc_req && !(ic_req && starve_cnt == CW'(STARVE_LIMIT));
   assign busy   = state != IDLE;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         owner      <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ic_ack     <= 1'b0;
         dc_ack     <= 1'b0;
         ic_data    <= '0;
         dc_data    <= '0;
      end else begin
         mem_req <= 1'b0;
         ic_ack  <= 1'b0;
         dc_ack  <= 1'b0;
         case (state)
            IDLE: if (ic_req || dc_req) begin
               state      <= ISSUE;
               owner      <= dc_win;
               mem_req    <= 1'b1;
               mem_we     <= dc_win && dc_we;
               mem_addr   <= (dc_win ? dc_addr : ic_addr) & ~32'hF;
               mem_wdata  <= dc_win ? dc_wdata : '0;
               // dc_win with ic_req pending implies the count is below the limit
               starve_cnt <= (dc_win && ic_req) ? starve_cnt + 1'b1 : '0;
            end
            ISSUE: state <= WAIT;
            WAIT: if (mem_ready) begin
               state   <= RESP;
               ic_ack  <= !owner;
               dc_ack  <= owner;
               ic_data <= owner ? ic_data : mem_rdata;
               dc_data <= (owner && !mem_we) ? mem_rdata : dc_data;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
